// File: rtl/bp_pkg.sv
// Shared types and saturating fixed-point helpers for the backprop delta pipe.
// Optional build macro BP_ROUND_EN: every right shift by frac_bits rounds half up
// instead of truncating toward -inf.
package bp_pkg;

  localparam int WORD_W = 12;

  typedef logic signed [WORD_W-1:0] word_t;

  // Number of fraction bits for a two's complement word with one sign bit
  function automatic int frac_bits(input int w, input int ib);
    return w - ib - 1;
  endfunction

  // Clamp a wide signed value into the range of a w-bit signed word
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Full-precision product rescaled by frac_bits, then clamped to w bits
  function automatic logic signed [63:0] sat_mul(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w, input int fb);
    logic signed [63:0] prod;
    prod = a * b;
`ifdef BP_ROUND_EN
    prod = prod + (64'sd1 <<< (fb - 1));
`endif
    return sat_w(prod >>> fb, w);
  endfunction

  // Sum clamped to w bits
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    return sat_w(a + b, w);
  endfunction

endpackage

// File: rtl/bp_lane.sv
// One lane of the delta pipe: S1 holds adot*wt and the lane's input delta,
// S2 forms p2 = p1*del and folds it into the running block accumulator.
// The sum output is what the accumulator would become on this beat, so the
// top can capture a finished block without an extra cycle.
module bp_lane
  import bp_pkg::*;
#(
  parameter int width    = WORD_W,
  parameter int int_bits = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             fire,
  input  logic             first,
  input  logic             last,
  input  logic [width-1:0] adot,
  input  logic [width-1:0] wt,
  input  logic [width-1:0] del,
  output logic [width-1:0] sum
);

  localparam int fb = frac_bits(width, int_bits);

  logic signed [width-1:0] p1_c;
  logic signed [width-1:0] p1_q;
  logic signed [width-1:0] del_q;
  logic signed [width-1:0] p2_c;
  logic signed [width-1:0] acc;

  assign p1_c = width'(sat_mul(64'($signed(adot)), 64'($signed(wt)), width, fb));
  assign p2_c = width'(sat_mul(64'(p1_q), 64'(del_q), width, fb));
  assign sum  = first ? p2_c : width'(sat_add(64'(acc), 64'(p2_c), width));

  // S1 captures the first product and delta; S2 restarts, extends or clears the block sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q  <= '0;
      del_q <= '0;
      acc   <= '0;
    end else begin
      if (!hold) begin
        p1_q  <= p1_c;
        del_q <= del;
      end
      if (fire) begin
        acc <= last ? '0 : sum;
      end
    end
  end

endmodule

// File: rtl/bp_processor_pipe.sv
// Handshaked backprop delta processor for one junction. z lanes each multiply
// adot*wt*del over a two-stage pipe and accumulate FO beats into one output
// block. A held output block stalls the whole pipe; nothing is dropped.
// Optional build macro BP_ROUND_EN selects round-half-up rescaling in the lanes.
module bp_processor_pipe
  import bp_pkg::*;
#(
  parameter int fi       = 2,
  parameter int z        = 4,
  parameter int width    = WORD_W,
  parameter int int_bits = 3,
  parameter int FO       = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [z/fi-1:0][width-1:0] del_in,
  input  logic [z-1:0][width-1:0]    adot_in,
  input  logic [z-1:0][width-1:0]    wt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [z-1:0][width-1:0]    del_out
);

  localparam int cw = (FO > 1) ? $clog2(FO) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic [cw-1:0]              cnt;
  logic [cw-1:0]              cnt_nxt;
  logic                       s1_valid;
  logic                       s1_valid_nxt;
  logic                       stall;
  logic                       take;
  logic                       fire;
  logic                       first;
  logic                       last;
  logic [z-1:0][width-1:0]    sum;

  assign out_valid = (state == FULL);
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign take      = in_valid && in_ready;
  assign fire      = s1_valid && !stall;
  assign first     = (cnt == '0);
  assign last      = (cnt == cw'(FO - 1));

  for (genvar i = 0; i < z; i++) begin : g_lane
    bp_lane #(
      .width    (width),
      .int_bits (int_bits)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .hold    (stall),
      .fire    (fire),
      .first   (first),
      .last    (last),
      .adot    (adot_in[i]),
      .wt      (wt[i]),
      .del     (del_in[i/fi]),
      .sum     (sum[i])
    );
  end

  // Block-level control: stage occupancy, beat count and the output-held state
  always_comb begin
    s1_valid_nxt = s1_valid;
    cnt_nxt      = cnt;
    state_nxt    = state;
    if (!stall) s1_valid_nxt = take;
    if (fire) cnt_nxt = last ? '0 : cnt + cw'(1);
    if (fire && last) state_nxt = FULL;
    else if (stall) state_nxt = FULL;
    else if (s1_valid_nxt || (cnt_nxt != '0)) state_nxt = ACCUM;
    else state_nxt = IDLE;
  end

  // Control registers; reset throws away any partial block and in-flight beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      s1_valid <= s1_valid_nxt;
    end
  end

  // Finished block is captured as the last beat leaves S2 and held until drained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      del_out <= '0;
    end else if (fire && last) begin
      del_out <= sum;
    end
  end

endmodule

// File: tb/tb_bp_processor_pipe.sv
// Scoreboard bench for bp_processor_pipe (FO=2 build). Accepted beats feed an
// arithmetic reference model that pushes finished blocks into a queue; an
// independent monitor compares every presented block against the queue head.
module tb_bp_processor_pipe;

  localparam int FI = 2;
  localparam int Z  = 4;
  localparam int W  = 12;
  localparam int IB = 3;
  localparam int FO = 2;
  localparam int FB = W - IB - 1;
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [Z/FI-1:0][W-1:0]  del_in;
  logic [Z-1:0][W-1:0]     adot_in;
  logic [Z-1:0][W-1:0]     wt;
  logic                    out_valid;
  logic                    out_ready;
  logic [Z-1:0][W-1:0]     del_out;

  longint                  part [Z];
  int                      part_n;
  logic [Z*W-1:0]          exp_q [$];
  int                      checks;
  int                      passes;
  bit                      hold_ready;
  bit                      rand_ready;

  bp_processor_pipe #(
    .fi       (FI),
    .z        (Z),
    .width    (W),
    .int_bits (IB),
    .FO       (FO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .del_in    (del_in),
    .adot_in   (adot_in),
    .wt        (wt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .del_out   (del_out)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Clamp to the signed word range
  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // Rescale a double-width product back to the word's fixed point
  function automatic longint rescale(input longint v);
`ifdef BP_ROUND_EN
    return (v + (longint'(1) <<< (FB - 1))) >>> FB;
`else
    return v >>> FB;
`endif
  endfunction

  // Either a small value around zero or any word, to hit both normal and clamped paths
  function automatic logic [W-1:0] rnd();
    int v;
    if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 1023)) - 512;
    else v = int'($urandom_range(0, 4095));
    return W'(v);
  endfunction

  // Compare, count, and report
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference model: one accepted beat; every FO beats emit an expected block
  task automatic modelAccept(input logic [Z/FI-1:0][W-1:0] d, input logic [Z-1:0][W-1:0] a,
                             input logic [Z-1:0][W-1:0] w);
    logic [Z-1:0][W-1:0] e;
    for (int l = 0; l < Z; l++) begin
      longint p1;
      longint p2;
      p1 = sat(rescale(longint'($signed(a[l])) * longint'($signed(w[l]))));
      p2 = sat(rescale(p1 * longint'($signed(d[l/FI]))));
      if (part_n == 0) part[l] = p2;
      else part[l] = sat(part[l] + p2);
    end
    part_n++;
    if (part_n == FO) begin
      for (int l = 0; l < Z; l++) e[l] = W'(part[l]);
      exp_q.push_back(e);
      part_n = 0;
    end
  endtask

  // Present one beat (entered at posedge+2) and hold it until accepted
  task automatic applyStimulus(input logic [Z/FI-1:0][W-1:0] d, input logic [Z-1:0][W-1:0] a,
                               input logic [Z-1:0][W-1:0] w);
    bit done;
    int guard;
    done  = 0;
    guard = 0;
    in_valid = 1'b1;
    del_in   = d;
    adot_in  = a;
    wt       = w;
    while (!done) begin
      #6;
      if (in_ready) begin
        done = 1;
        modelAccept(d, a, w);
      end
      @(posedge clk);
      #2;
      guard++;
      if (!done && guard > 200) begin
        checks++;
        $display("[TB] FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic randomBeat();
    logic [Z/FI-1:0][W-1:0] d;
    logic [Z-1:0][W-1:0]    a;
    logic [Z-1:0][W-1:0]    w;
    for (int i = 0; i < Z / FI; i++) d[i] = rnd();
    for (int i = 0; i < Z; i++) begin
      a[i] = rnd();
      w[i] = rnd();
    end
    applyStimulus(d, a, w);
  endtask

  // Wait until every expected block has been drained
  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      idle(1);
      guard++;
    end
    checkOutput(name, 64'(exp_q.size()), 64'(0));
  endtask

  // Consumer side: drives out_ready, forced low on request or randomly throttled
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_ready) out_ready = 1'b0;
      else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  // Monitor: every cycle a block is presented it must match the queue head;
  // a held block must also be blocking new input
  initial begin
    forever begin
      @(posedge clk);
      #8;
      if (reset_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_block: got %h, expected no block", del_out);
        end else begin
          checkOutput("del_out", 64'(del_out), 64'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_ready) checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
      end
    end
  end

  // Global time limit
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, %0d blocks outstanding, expected 0", exp_q.size());
    $fatal(1, "[TB] time limit");
  end

  logic [Z/FI-1:0][W-1:0] sd;
  logic [Z-1:0][W-1:0]    sa;
  logic [Z-1:0][W-1:0]    sw;
  logic [Z-1:0][W-1:0]    zw;

  initial begin
    checks     = 0;
    passes     = 0;
    part_n     = 0;
    hold_ready = 0;
    rand_ready = 0;
    in_valid   = 1'b0;
    del_in     = '0;
    adot_in    = '0;
    wt         = '0;
    sd = {12'hF00, 12'h280};
    sa = {12'h0C0, 12'h080, 12'h040, 12'h000};
    sw = {12'hD00, 12'hE00, 12'hF00, 12'h000};
    zw = '0;

    // Power-on reset
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_del_out", 64'(del_out), 64'(0));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    #6;
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2;

    // Single-beat result: second beat has zero weights, so block equals one beat
    applyStimulus(sd, sa, sw);
    applyStimulus(sd, sa, zw);
    exp_q[exp_q.size()-1] = {12'h240, 12'h100, 12'hF60, 12'h000};
    #6;
    checkOutput("latency_early", 64'(out_valid), 64'(0));
    @(posedge clk);
    #6;
    checkOutput("latency_rise", 64'(out_valid), 64'(1));
    @(posedge clk);
    #2;

    // Same beat twice accumulates
    applyStimulus(sd, sa, sw);
    applyStimulus(sd, sa, sw);
    exp_q[exp_q.size()-1] = {12'h480, 12'h200, 12'hEC0, 12'h000};

    // Positive and negative saturation, clamped through accumulation
    applyStimulus({2{12'h7FF}}, {4{12'h7FF}}, {4{12'h7FF}});
    applyStimulus({2{12'h7FF}}, {4{12'h7FF}}, {4{12'h7FF}});
    exp_q[exp_q.size()-1] = {4{12'h7FF}};
    applyStimulus({2{12'h7FF}}, {4{12'h7FF}}, {4{12'h800}});
    applyStimulus({2{12'h7FF}}, {4{12'h7FF}}, {4{12'h800}});
    exp_q[exp_q.size()-1] = {4{12'h800}};

    // Rescale rounding: 1*0x80 lands exactly on the half-LSB boundary
    applyStimulus({2{12'h100}}, {4{12'h001}}, {4{12'h080}});
    applyStimulus({2{12'h100}}, {4{12'h001}}, {4{12'h080}});
`ifdef BP_ROUND_EN
    exp_q[exp_q.size()-1] = {4{12'h002}};
`else
    exp_q[exp_q.size()-1] = {4{12'h000}};
`endif
    waitDrain("drain_directed");

    // Backpressure: block completes while the consumer refuses it
    hold_ready = 1;
    idle(1);
    randomBeat();
    randomBeat();
    begin
      int guard;
      guard = 0;
      while (!out_valid && guard < 20) begin
        idle(1);
        guard++;
      end
      checkOutput("bp_block_ready", 64'(out_valid), 64'(1));
    end
    idle(3);
    checkOutput("bp_held_valid", 64'(out_valid), 64'(1));
    hold_ready = 0;
    waitDrain("drain_backpressure");

    // Reset in the middle of a block
    applyStimulus(sd, sa, sw);
    idle(1);
    reset_n = 1'b0;
    part_n  = 0;
    exp_q.delete();
    #2;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_del_out", 64'(del_out), 64'(0));
    idle(1);
    reset_n = 1'b1;
    idle(1);
    applyStimulus(sd, sa, sw);
    applyStimulus(sd, sa, sw);
    exp_q[exp_q.size()-1] = {12'h480, 12'h200, 12'hEC0, 12'h000};
    waitDrain("drain_after_reset");

    // Randomized traffic with bubbles and a throttled consumer
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      randomBeat();
    end
    rand_ready = 0;
    waitDrain("drain_random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
